// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store/fetch engine between the
// control FSM and a variable-latency memory with valid/ready request and
// rvalid read-response handshakes.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to enable a watchdog that
// aborts a stalled access after TIMEOUT_CYCLES cycles with bus_error.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  fault,
    output logic                  bus_error,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_maddr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_timeout;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic [31:0]           w_shift;
    logic [31:0]           w_load;

    // Decode the incoming request: legality, alignment, lane enables and store data
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            3'b100, 3'b101:         w_illegal = req_write;  // no unsigned stores
            default:                w_illegal = 1'b0;
        endcase

        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << req_addr[1:0];
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the response word and extend it
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake outputs; completion wins over a same-cycle timeout
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        mem_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid)
                    w_next = (w_illegal || w_misaligned) ? S_FAULT : S_REQ;
            end
            S_REQ: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                if (mem_ready)      w_next = r_write ? S_DONE : S_RESP;
                else if (w_timeout) w_next = S_DONE;
            end
            S_RESP: begin
                busy = 1'b1;
                if (mem_rvalid)     w_next = S_DONE;
                else if (w_timeout) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_FAULT: begin
                busy   = 1'b1;
                done   = 1'b1;
                fault  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture request fields on acceptance; latch extended load data on rvalid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_maddr  <= '0;
            r_be     <= 4'b0000;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                r_maddr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_wdata_rep;
            end
            if (r_state == S_RESP && mem_rvalid)
                r_rdata <= w_load;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_berr;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = (r_state == S_DONE) && r_berr;

    // Watchdog: zero while idle (so it starts at 0 in REQ), count through REQ/RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_berr <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_cnt <= '0;
            else if (r_state == S_REQ || r_state == S_RESP)
                r_cnt <= r_cnt + CNT_W'(1);
            r_berr <= w_timeout &&
                      ((r_state == S_REQ  && !mem_ready) ||
                       (r_state == S_RESP && !mem_rvalid));
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_error = 1'b0;
`endif

    assign rdata     = r_rdata;
    assign mem_we    = r_write;
    assign mem_addr  = r_maddr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: each request pushes its expected
// completion (cycle, rdata, fault, bus_error); a monitor pops on done.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk, reset;
  logic          req_valid, req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          busy, done, fault, bus_error;
  logic [31:0]   rdata;
  logic          mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .fault(fault), .bus_error(bus_error),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        flt;
    logic        berr;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0;
  int          mv_cnt = 0;
  logic [31:0] model_rd = 32'h0;

  // memory responder knobs
  int          ready_dly = 0, rv_dly = 0;
  logic [31:0] rword = 32'h0;
  logic        early_rv = 1'b0, stuck = 1'b0;
  int          wcnt = 0, rcnt = -1;

  // expected bus values while mem_valid
  logic [AW-1:0] x_addr;
  logic [3:0]    x_be;
  logic          x_we;
  logic [31:0]   x_wd;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, act, exp);
  endtask

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  // variable-latency memory model, driven at negedge
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (rcnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rword; rcnt = -1; end
      else if (rcnt > 0) rcnt--;
      if (mem_valid && !stuck) begin
        if (wcnt == ready_dly) begin
          mem_ready = 1'b1; wcnt = 0;
          if (!mem_we) rcnt = rv_dly;
          if (early_rv) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // monitor: completions against scoreboard, bus stability, quiet flags
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (done) begin
        if (q.size() == 0) chk("spurious_done", {31'h0, done}, 32'h0);
        else begin
          e = q.pop_front();
          chk("done_cyc", cyc, e.cyc);
          chk("rdata", rdata, e.rd);
          chk("fault", {31'h0, fault}, {31'h0, e.flt});
          chk("bus_error", {31'h0, bus_error}, {31'h0, e.berr});
          chk("busy_at_done", {31'h0, busy}, 32'h1);
        end
      end else chk("flags_quiet", {30'h0, fault, bus_error}, 32'h0);
      if (mem_valid) begin
        mv_cnt++;
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_be", {28'h0, mem_be}, {28'h0, x_be});
        chk("mem_we", {31'h0, mem_we}, {31'h0, x_we});
        if (x_we) chk("mem_wdata", mem_wdata, x_wd);
      end
    end
  end

  task automatic wait_drain(input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin @(negedge clk); n++; end
    if (q.size() != 0) begin chk("drain_timeout", q.size(), 0); q.delete(); end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  // one access: bad = expect fault; xrd used for loads only
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdly, input int rvd,
                        input logic [31:0] word, input logic early,
                        input logic [3:0] xbe, input logic [31:0] xwd,
                        input logic [31:0] xrd, input logic bad);
    exp_t e;
    int   c0;
    @(posedge clk); #1;
    ready_dly = rdly; rv_dly = rvd; rword = word; early_rv = early;
    x_addr = {a[31:2], 2'b00}; x_be = xbe; x_we = wr; x_wd = xwd;
    drive_req(wr, f3, a, wd);
    c0 = cyc; mv_cnt = 0;
    e.flt = bad; e.berr = 1'b0; e.rd = model_rd;
    if (bad)      e.cyc = c0 + 1;
    else if (wr)  e.cyc = c0 + 2 + rdly;
    else begin    e.cyc = c0 + 3 + rdly + rvd; e.rd = xrd; model_rd = xrd; end
    q.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_drain(60);
    @(negedge clk);
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("mem_valid_cycles", mv_cnt, bad ? 0 : rdly + 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_flags"}, {30'h0, fault, bus_error}, 32'h0);
  endtask

  initial begin
    exp_t e;
    int   c0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    //     wr  f3      addr       wdata        rdy rv word          early be       xwd           xrd           bad
    access(0, 3'b010, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    access(0, 3'b000, 32'h203, 32'h0,        0, 0, 32'h80FF1234, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
    access(0, 3'b100, 32'h203, 32'h0,        0, 0, 32'h80FF1234, 0, 4'b1000, 32'h0,        32'h00000080, 0);
    access(1, 3'b001, 32'h302, 32'h0000ABCD, 3, 0, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0,        0);
    access(0, 3'b001, 32'h102, 32'h0,        1, 2, 32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0);
    access(0, 3'b101, 32'h100, 32'h0,        0, 0, 32'h80017FFF, 0, 4'b0011, 32'h0,        32'h00007FFF, 0);
    access(1, 3'b000, 32'h101, 32'h12345678, 0, 0, 32'h0,        0, 4'b0010, 32'h78787878, 32'h0,        0);
    access(1, 3'b010, 32'h000, 32'hCAFEF00D, 1, 0, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    access(0, 3'b010, 32'h104, 32'h0,        0, 1, 32'h11112222, 1, 4'b1111, 32'h0,        32'h11112222, 0);
    // faults: misaligned LW, illegal funct3, unsigned store, misaligned LH
    access(0, 3'b010, 32'h101, 32'h0,        0, 0, 32'h0,        0, 4'b1111, 32'h0,        32'h0,        1);
    access(0, 3'b011, 32'h200, 32'h0,        0, 0, 32'h0,        0, 4'b1111, 32'h0,        32'h0,        1);
    access(1, 3'b100, 32'h200, 32'h55,       0, 0, 32'h0,        0, 4'b0001, 32'h0,        32'h0,        1);
    access(0, 3'b001, 32'h103, 32'h0,        0, 0, 32'h0,        0, 4'b1000, 32'h0,        32'h0,        1);

    // req_valid held: second request dropped while busy, re-accepted after done
    @(posedge clk); #1;
    drive_req(0, 3'b010, 32'h101, 32'h0);
    c0 = cyc; mv_cnt = 0;
    e.rd = model_rd; e.flt = 1'b1; e.berr = 1'b0;
    e.cyc = c0 + 1; q.push_back(e);
    e.cyc = c0 + 3; q.push_back(e);
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    wait_drain(20);
    chk("b2b_mem_valid_cycles", mv_cnt, 0);

    // reset while waiting in RESP; the late rvalid must be ignored
    @(posedge clk); #1;
    ready_dly = 0; rv_dly = 3; rword = 32'h5555AAAA; early_rv = 1'b0;
    x_addr = 32'h400; x_be = 4'b1111; x_we = 1'b0;
    drive_req(0, 3'b010, 32'h400, 32'h0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    model_rd = 32'h0;
    repeat (5) @(negedge clk);
    chk("midreset_late_rdata", rdata, 32'h0);
    chk("midreset_late_busy", {31'h0, busy}, 32'h0);

    // memory never answers
    stuck = 1'b1;
    @(posedge clk); #1;
    x_addr = 32'h10; x_be = 4'b1111; x_we = 1'b0;
    drive_req(0, 3'b010, 32'h10, 32'h0);
    c0 = cyc;
`ifdef MEM_ACCESS_TIMEOUT_EN
    e.rd = model_rd; e.flt = 1'b0; e.berr = 1'b1; e.cyc = c0 + 1 + TO;
    q.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_drain(40);
    @(negedge clk);
    chk("timeout_busy", {31'h0, busy}, 32'h0);
    chk("timeout_mem_valid", {31'h0, mem_valid}, 32'h0);
`else
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_busy", {31'h0, busy}, 32'h1);
    chk("stall_mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("stall_bus_error", {31'h0, bus_error}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_rd = 32'h0;
    @(negedge clk);
    chk("stall_reset_busy", {31'h0, busy}, 32'h0);
`endif
    stuck = 1'b0;

    // unit still works after the stall/abort
    access(0, 3'b000, 32'h001, 32'h0, 0, 0, 32'h00007F00, 0, 4'b0010, 32'h0, 32'h0000007F, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multicycle load/store/fetch access engine between the control FSM/datapath and an external variable-latency memory.
- Accepts one request at a time and performs a valid/ready request handshake plus a read-response handshake on the memory side.
- Generates byte enables and lane-replicated store data from funct3; extracts and sign/zero-extends load data.
- Reports completion, faults and busy so the control FSM holds its memory states until the access finishes.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_addr.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  access request; sampled only in IDLE
- req_write  input  1  1 = store, 0 = load/fetch
- req_funct3  input  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data (rs2)
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle completion pulse
- rdata  output  32  extended load result, held until the next load completes
- fault  output  1  valid with done: misaligned address or illegal funct3
- bus_error  output  1  valid with done: watchdog abort
- mem_valid  output  1  memory request valid
- mem_ready  input  1  memory accepts request
- mem_we  output  1  write strobe qualifier
- mem_addr  output  ADDR_WIDTH  word-aligned address: {req_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_rvalid  input  1  read response valid
- mem_rdata  input  32  read response word

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state = IDLE.
  - busy, done, fault, bus_error, mem_valid, mem_we = 0.
  - mem_be = 0; rdata, mem_addr, mem_wdata = 0.
- IDLE:
  - On req_valid, register all request fields.
  - Illegal funct3 is any of: 011, 110, 111, or 100/101 with req_write = 1.
  - Misaligned is: H with addr[0] = 1, or W with addr[1:0] != 0.
  - If illegal or misaligned, go to FAULT. Otherwise go to REQ.
  - mem_rvalid is ignored in IDLE.
- REQ:
  - mem_valid = 1; mem_addr/mem_we/mem_be/mem_wdata are stable and driven from registers.
  - On mem_valid && mem_ready: a store goes to DONE; a load goes to RESP. mem_valid drops the next cycle.
- RESP:
  - Wait for mem_rvalid; the earliest legal rvalid is the cycle after the ready handshake.
  - rvalid in the same cycle as ready is not sampled.
  - On rvalid, load rdata from mem_rdata and go to DONE.
- Load extraction: sh = 8 * addr[1:0].
  - LB/LBU: byte at mem_rdata[sh+7:sh], sign- or zero-extended.
  - LH/LHU: halfword at mem_rdata[sh+15:sh], sign- or zero-extended.
  - LW: the full word.
- Store lanes:
  - SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = 4'b0011 << addr[1:0]; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = wdata.
  - Loads drive mem_be with the same enables; mem_we = 0 for loads.
- DONE: done = 1 for one cycle with fault = 0; return to IDLE.
- FAULT: done = 1 and fault = 1 for one cycle; no memory transaction; rdata unchanged; return to IDLE.
- busy is 1 in REQ, RESP, DONE and FAULT.
- A new req_valid is accepted in IDLE only; requests presented while busy are dropped.
  - Back-to-back requests: the earliest re-acceptance is the cycle after done.
- Latency:
  - Store with zero-wait memory: accept at cycle 0, mem_valid at 1, ready at 1, done at 2.
  - Load with zero-wait memory and rvalid at cycle 2: done at 3.
- Reset mid-operation: next state is IDLE and mem_valid drops at that edge. A late rvalid is discarded and rdata is reset to 0.
- fault and bus_error are 0 whenever done = 0.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 without completing, the unit goes to DONE with bus_error = 1 and fault = 0.
  - rdata is unchanged and mem_valid is dropped.
- Undefined: no counter exists, bus_error is tied to 0, and the unit waits indefinitely.

Test Plan:
- LW addr 0x100, mem_ready = 1 immediately, rvalid at +1 with rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 1111, done at cycle 3, rdata 0xDEADBEEF, fault 0.
- LB addr 0x203, rdata word 0x80FF_1234 -> mem_addr 0x200, rdata 0xFFFFFF80; repeat with LBU -> 0x00000080.
- SH addr 0x302, wdata 0x0000ABCD, mem_ready delayed 3 cycles -> mem_valid held 4 cycles with stable outputs, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, done one cycle after ready.
- LW addr 0x101, then funct3 = 011 -> each produces done + fault the cycle after accept, mem_valid never asserts, rdata unchanged.
- Reset asserted while in RESP, then rvalid arrives -> mem_valid 0 and all outputs 0 after the reset edge, no done, rvalid ignored.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready stuck at 0 -> done + bus_error exactly 8 cycles after entering REQ, then IDLE; without the macro, busy stays high and bus_error = 0.
